// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered-read or first-word-fall-through output.
// Latency: write visible in count/flags one cycle later; FWFT=0 read data one cycle after pop, FWFT=1 head word shown combinationally.
// Backpressure: writes while full and reads while empty are dropped and latch sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             err_clr,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;

    localparam logic [ASIZE:0] L_DEPTH = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] L_AF    = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] L_AE    = (ASIZE+1)'(AE_LEVEL);

    // Reject illegal geometry and threshold settings at elaboration.
    if (DSIZE < 1) begin : g_bad_dsize
        $error("sync_fifo_param: DSIZE must be >= 1");
    end
    if (ASIZE < 1) begin : g_bad_asize
        $error("sync_fifo_param: ASIZE must be >= 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    logic [ASIZE:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;

    // Level flags are pure decodes of the registered count, so they move only after an edge.
    assign count         = r_count;
    assign wfull         = (r_count == L_DEPTH);
    assign rempty        = (r_count == '0);
    assign walmost_full  = (r_count >= L_AF);
    assign ralmost_empty = (r_count <= L_AE);
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

    // Acceptance looks only at the current flags: no write-through-full, no read bypass on empty.
    assign w_wr_acc = winc & ~wfull;
    assign w_rd_acc = rinc & ~rempty;

    // Storage array is deliberately left unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks the net of accepted writes and reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + ASIZE'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + ASIZE'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + (ASIZE+1)'(1);
                2'b01:   r_count <= r_count - (ASIZE+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rinc && rempty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DSIZE-1:0] r_rdata;

        // Registered read port: loads the head word on an accepted pop, otherwise holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdata <= '0;
            end else if (w_rd_acc) begin
                r_rdata <= r_mem[r_rptr];
            end
        end

        assign rdata = r_rdata;
    end else begin : g_fwft_read
        // Head word is always presented; forced to zero while empty so reset shows a clean value.
        assign rdata = rempty ? '0 : r_mem[r_rptr];
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst_n;

    // Instance 0: defaults (8-bit, depth 16, AF 14, AE 2, registered read)
    logic [7:0]  w0_dat, r0_dat;
    logic        w0_inc, r0_inc, c0_clr;
    logic        wf0, re0, waf0, rae0, ovf0, unf0;
    logic [4:0]  cnt0;
    // Instance 1: FWFT, 16-bit, depth 4, AF 3, AE 1
    logic [15:0] w1_dat, r1_dat;
    logic        w1_inc, r1_inc, c1_clr;
    logic        wf1, re1, waf1, rae1, ovf1, unf1;
    logic [2:0]  cnt1;

    int checks = 0;
    int errors = 0;

    logic [10:0] st0;
    logic [8:0]  st1;
    assign st0 = {cnt0, wf0, re0, waf0, rae0, ovf0, unf0};
    assign st1 = {cnt1, wf1, re1, waf1, rae1, ovf1, unf1};

    always #5 clk = ~clk;

    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .wdata(w0_dat), .winc(w0_inc), .rinc(r0_inc), .err_clr(c0_clr),
        .rdata(r0_dat), .wfull(wf0), .rempty(re0), .walmost_full(waf0), .ralmost_empty(rae0),
        .count(cnt0), .overflow(ovf0), .underflow(unf0));

    sync_fifo_param #(.DSIZE(16), .ASIZE(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .wdata(w1_dat), .winc(w1_inc), .rinc(r1_inc), .err_clr(c1_clr),
        .rdata(r1_dat), .wfull(wf1), .rempty(re1), .walmost_full(waf1), .ralmost_empty(rae1),
        .count(cnt1), .overflow(ovf1), .underflow(unf1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Power-on reset state
        rst_n = 1'b0;
        step(); step();
        checks++;
        if (st0 !== 11'b00000_010100 || r0_dat !== 8'h00) begin
            errors++;
            $display("FAIL reset_por: state=%b rdata=%h expected state=00000010100 rdata=00", st0, r0_dat);
        end
        rst_n = 1'b1;
        // Write 8, read 1 -> count 7, rdata 0x10
        for (int i = 0; i < 8; i++) begin
            w0_inc = 1'b1; w0_dat = 8'(8'h10 + i);
            step();
        end
        w0_inc = 1'b0; r0_inc = 1'b1;
        step();
        r0_inc = 1'b0;
        checks++;
        if (cnt0 !== 5'd7 || r0_dat !== 8'h10) begin
            errors++;
            $display("FAIL reset_pre: count=%0d rdata=%h expected count=7 rdata=10", cnt0, r0_dat);
        end
        // Asynchronous reset mid-burst, checked before any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (st0 !== 11'b00000_010100 || r0_dat !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: state=%b rdata=%h expected state=00000010100 rdata=00", st0, r0_dat);
        end
        step();
        rst_n = 1'b1;
        w0_inc = 1'b1; w0_dat = 8'hA5;
        step();
        w0_inc = 1'b0; r0_inc = 1'b1;
        step();
        r0_inc = 1'b0;
        checks++;
        if (r0_dat !== 8'hA5 || cnt0 !== 5'd0) begin
            errors++;
            $display("FAIL reset_first_write: rdata=%h count=%0d expected rdata=a5 count=0", r0_dat, cnt0);
        end
    endtask

    task automatic test_fill_drain();
        logic [10:0] e;
        for (int k = 1; k <= 16; k++) begin
            w0_inc = 1'b1; w0_dat = 8'(k);
            step();
            e = {5'(k), 1'(k == 16), 1'b0, 1'(k >= 14), 1'(k <= 2), 2'b00};
            checks++;
            if (st0 !== e) begin
                errors++;
                $display("FAIL fill_%0d: state=%b expected %b", k, st0, e);
            end
        end
        w0_dat = 8'h99;
        step();
        w0_inc = 1'b0;
        checks++;
        if (cnt0 !== 5'd16 || ovf0 !== 1'b1 || wf0 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_17th: count=%0d ovf=%b wfull=%b expected count=16 ovf=1 wfull=1", cnt0, ovf0, wf0);
        end
        for (int k = 1; k <= 16; k++) begin
            r0_inc = 1'b1;
            step();
            checks++;
            if (r0_dat !== 8'(k)) begin
                errors++;
                $display("FAIL drain_%0d: rdata=%h expected %h", k, r0_dat, 8'(k));
            end
        end
        r0_inc = 1'b0;
        checks++;
        if (re0 !== 1'b1 || rae0 !== 1'b1 || cnt0 !== 5'd0 || waf0 !== 1'b0) begin
            errors++;
            $display("FAIL drained_flags: rempty=%b ralmost_empty=%b count=%0d waf=%b expected 1 1 0 0", re0, rae0, cnt0, waf0);
        end
    endtask

    task automatic test_wrap();
        c0_clr = 1'b1;
        step();
        c0_clr = 1'b0;
        checks++;
        if (ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_clr: ovf=%b expected 0", ovf0);
        end
        for (int k = 0; k < 40; k++) begin
            w0_inc = 1'b1; w0_dat = 8'(k + 4);
            step();
            w0_inc = 1'b0; r0_inc = 1'b1;
            checks++;
            if (cnt0 !== 5'd1) begin
                errors++;
                $display("FAIL wrap_cnt1_%0d: count=%0d expected 1", k, cnt0);
            end
            step();
            r0_inc = 1'b0;
            checks++;
            if (r0_dat !== 8'(k + 4) || cnt0 !== 5'd0) begin
                errors++;
                $display("FAIL wrap_rd_%0d: rdata=%h count=%0d expected %h count=0", k, r0_dat, cnt0, 8'(k + 4));
            end
        end
    endtask

    task automatic test_boundaries();
        for (int k = 0; k < 16; k++) begin
            w0_inc = 1'b1; w0_dat = 8'(8'h30 + k);
            step();
        end
        // Full with both requests: read wins, write rejected
        w0_dat = 8'hEE; r0_inc = 1'b1;
        step();
        w0_inc = 1'b0; r0_inc = 1'b0;
        checks++;
        if (cnt0 !== 5'd15 || ovf0 !== 1'b1 || r0_dat !== 8'h30) begin
            errors++;
            $display("FAIL full_both: count=%0d ovf=%b rdata=%h expected 15 1 30", cnt0, ovf0, r0_dat);
        end
        r0_inc = 1'b1;
        for (int k = 0; k < 15; k++) step();
        r0_inc = 1'b0;
        checks++;
        if (r0_dat !== 8'h3F || cnt0 !== 5'd0) begin
            errors++;
            $display("FAIL full_drain: rdata=%h count=%0d expected 3f 0", r0_dat, cnt0);
        end
        // Empty with both requests: write accepted, read rejected, rdata held
        w0_inc = 1'b1; w0_dat = 8'h77; r0_inc = 1'b1;
        step();
        w0_inc = 1'b0; r0_inc = 1'b0;
        checks++;
        if (cnt0 !== 5'd1 || unf0 !== 1'b1 || ovf0 !== 1'b1 || r0_dat !== 8'h3F) begin
            errors++;
            $display("FAIL empty_both: count=%0d unf=%b ovf=%b rdata=%h expected 1 1 1 3f", cnt0, unf0, ovf0, r0_dat);
        end
        c0_clr = 1'b1;
        step();
        c0_clr = 1'b0;
        checks++;
        if (ovf0 !== 1'b0 || unf0 !== 1'b0 || cnt0 !== 5'd1) begin
            errors++;
            $display("FAIL err_clr: ovf=%b unf=%b count=%0d expected 0 0 1", ovf0, unf0, cnt0);
        end
        r0_inc = 1'b1;
        step();
        checks++;
        if (r0_dat !== 8'h77 || cnt0 !== 5'd0) begin
            errors++;
            $display("FAIL empty_both_data: rdata=%h count=%0d expected 77 0", r0_dat, cnt0);
        end
        // Set beats clear in the same cycle
        c0_clr = 1'b1;
        step();
        r0_inc = 1'b0; c0_clr = 1'b0;
        checks++;
        if (unf0 !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: unf=%b expected 1", unf0);
        end
    endtask

    task automatic test_fwft();
        reset_dut();
        w1_inc = 1'b1; w1_dat = 16'h1234;
        step();
        w1_inc = 1'b0;
        checks++;
        if (r1_dat !== 16'h1234 || re1 !== 1'b0 || cnt1 !== 3'd1) begin
            errors++;
            $display("FAIL fwft_fall: rdata=%h rempty=%b count=%0d expected 1234 0 1", r1_dat, re1, cnt1);
        end
        r1_inc = 1'b1;
        step();
        r1_inc = 1'b0;
        checks++;
        if (re1 !== 1'b1 || cnt1 !== 3'd0) begin
            errors++;
            $display("FAIL fwft_pop: rempty=%b count=%0d expected 1 0", re1, cnt1);
        end
        for (int k = 0; k < 4; k++) begin
            w1_inc = 1'b1; w1_dat = 16'(16'hA000 + k);
            step();
            checks++;
            if (st1 !== {3'(k + 1), 1'(k == 3), 1'b0, 1'(k >= 2), 1'(k == 0), 2'b00} || r1_dat !== 16'hA000) begin
                errors++;
                $display("FAIL fwft_fill_%0d: state=%b rdata=%h expected head a000", k + 1, st1, r1_dat);
            end
        end
        w1_inc = 1'b0; r1_inc = 1'b1;
        step();
        r1_inc = 1'b0;
        checks++;
        if (r1_dat !== 16'hA001 || cnt1 !== 3'd3 || wf1 !== 1'b0) begin
            errors++;
            $display("FAIL fwft_next: rdata=%h count=%0d wfull=%b expected a001 3 0", r1_dat, cnt1, wf1);
        end
    endtask

    task automatic test_random(input int sel, input int depth, input int af, input int ae,
                               input int fwft, input int wpct, input int rpct, input int n);
        int q[$];
        int mrd, obs_st, exp_st, obs_rd, d;
        bit movf, munf, wi, ri, cl, full, empty;
        mrd = 0; movf = 0; munf = 0;
        reset_dut();
        for (int c = 0; c < n; c++) begin
            wi = ($urandom_range(99) < wpct);
            ri = ($urandom_range(99) < rpct);
            cl = ($urandom_range(99) < 5);
            d  = int'($urandom_range(sel != 0 ? 65535 : 255));
            if (sel == 0) begin
                w0_inc = wi; r0_inc = ri; c0_clr = cl; w0_dat = 8'(d);
            end else begin
                w1_inc = wi; r1_inc = ri; c1_clr = cl; w1_dat = 16'(d);
            end
            full  = (q.size() == depth);
            empty = (q.size() == 0);
            if (ri && !empty) begin
                if (fwft == 0) mrd = q[0];
                void'(q.pop_front());
            end
            if (wi && !full) q.push_back(d);
            movf = (wi && full)  ? 1'b1 : (cl ? 1'b0 : movf);
            munf = (ri && empty) ? 1'b1 : (cl ? 1'b0 : munf);
            step();
            exp_st = (q.size() << 6) | (int'(q.size() == depth) << 5) | (int'(q.size() == 0) << 4)
                   | (int'(q.size() >= af) << 3) | (int'(q.size() <= ae) << 2) | (int'(movf) << 1) | int'(munf);
            obs_st = (sel == 0) ? int'(st0) : int'(st1);
            obs_rd = (sel == 0) ? int'(r0_dat) : int'(r1_dat);
            checks++;
            if (obs_st !== exp_st) begin
                errors++;
                $display("FAIL rand%0d_state_c%0d: state=%h expected %h", sel, c, obs_st, exp_st);
            end
            if (fwft == 0 || q.size() > 0) begin
                checks++;
                if (obs_rd !== ((fwft == 0) ? mrd : q[0])) begin
                    errors++;
                    $display("FAIL rand%0d_rdata_c%0d: rdata=%h expected %h", sel, c, obs_rd, (fwft == 0) ? mrd : q[0]);
                end
            end
        end
        w0_inc = 1'b0; r0_inc = 1'b0; c0_clr = 1'b0;
        w1_inc = 1'b0; r1_inc = 1'b0; c1_clr = 1'b0;
    endtask

    initial begin
        w0_dat = '0; w0_inc = 1'b0; r0_inc = 1'b0; c0_clr = 1'b0;
        w1_dat = '0; w1_inc = 1'b0; r1_inc = 1'b0; c1_clr = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_boundaries();
        test_fwft();
        test_random(0, 16, 14, 2, 0, 90, 10, 300);
        test_random(0, 16, 14, 2, 0, 10, 90, 200);
        test_random(0, 16, 14, 2, 0, 50, 50, 300);
        test_random(1, 4, 3, 1, 1, 90, 10, 200);
        test_random(1, 4, 3, 1, 1, 10, 90, 200);
        test_random(1, 4, 3, 1, 1, 60, 60, 300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
